// File: rtl/fixed_point_normalizer_pkg.sv
// -----------------------------------------------------------------------------
// fixed_point_pkg
//   Shared definitions for the fixed-point normalizer slice.
//   - clz_width(n): width of a leading-zero count over an n-bit operand.
//   - norm_result_t: normalizer result record {mant, shift, sign, zero}, sized
//     for the widest supported operand so any instance width fits in it.
// -----------------------------------------------------------------------------
package fixed_point_pkg;

  // Widest operand the normalizer is built for.
  localparam int unsigned MAX_N = 64;

  // Bits needed to hold a leading-zero count for an n-bit operand. The count
  // never has to represent n itself: an all-zero operand reports 0.
  function automatic int unsigned clz_width(input int unsigned n);
    return $clog2(n);
  endfunction

  localparam int unsigned MAX_SHIFT_W = clz_width(MAX_N);

  typedef struct packed {
    logic [MAX_N-1:0]       mant;
    logic [MAX_SHIFT_W-1:0] shift;
    logic                   sign;
    logic                   zero;
  } norm_result_t;

endpackage

// File: rtl/fixed_point_clz_tree.sv
// -----------------------------------------------------------------------------
// fixed_point_clz_tree
//   Combinational leading-zero counter built as a pairwise reduction tree.
//   Ports:
//     data : N-bit operand
//     clz  : number of leading zeros of data; 0 when data is all zeros
//   N must be a power of two.
// -----------------------------------------------------------------------------
module fixed_point_clz_tree
  import fixed_point_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0]            data,
  output logic [clz_width(N)-1:0] clz
);

  localparam int unsigned SW = clz_width(N);

  // Heap-ordered tree: node 0 is the root, node k has children 2k+1 (upper
  // half of its bit range) and 2k+2 (lower half). Leaves start at N-1, with
  // the leftmost leaf holding the operand MSB.
  logic          v_s [2*N-1];
  logic [SW-1:0] c_s [2*N-1];

  for (genvar j = 0; j < N; j++) begin : g_leaf
    assign v_s[N-1+j] = data[N-1-j];
    assign c_s[N-1+j] = {SW{1'b0}};
  end

  // A node whose upper half is all zero adds the full width of that half to
  // the lower half's count. The half width is a single bit of the count
  // because each child count is strictly smaller than it.
  for (genvar k = 0; k < N - 1; k++) begin : g_node
    localparam int DEPTH = $clog2(k + 2) - 1;
    localparam logic [SW-1:0] WEIGHT = {{(SW-1){1'b0}}, 1'b1} << (SW - 1 - DEPTH);
    assign v_s[k] = v_s[2*k+1] | v_s[2*k+2];
    assign c_s[k] = v_s[2*k+1] ? c_s[2*k+1] : (c_s[2*k+2] | WEIGHT);
  end

  // An all-zero operand would otherwise count N-1; report 0 instead.
  always_comb begin
    if (v_s[0]) begin
      clz = c_s[0];
    end else begin
      clz = {SW{1'b0}};
    end
  end

endmodule

// File: rtl/fixed_point_normalizer.sv
// -----------------------------------------------------------------------------
// fixed_point_normalizer
//   Three-stage leading-zero normalizer with a valid/ready handshake.
//   S1: sign and magnitude, S2: zero flag and leading-zero count,
//   S3: normalized mantissa. All outputs come straight from S3 flops.
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     in_valid/in_ready    : input handshake (in_ready depends only on
//                            out_valid and out_ready)
//     in_data [N]          : operand (two's complement when SIGNED = 1)
//     out_valid/out_ready  : output handshake
//     out_mant [N]         : magnitude shifted so its MSB is 1 (0 for zero)
//     out_shift [log2 N]   : left shift applied (leading zeros of magnitude)
//     out_sign             : operand sign, always 0 when SIGNED = 0
//     out_zero             : operand was zero
// -----------------------------------------------------------------------------
module fixed_point_normalizer
  import fixed_point_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_mant,
  output logic [clz_width(N)-1:0] out_shift,
  output logic                    out_sign,
  output logic                    out_zero
);

  localparam int unsigned SW = clz_width(N);

  logic          advance_s;
  logic          s1_sign_nxt_s;
  logic [N-1:0]  s1_mag_nxt_s;
  logic [SW-1:0] s1_clz_s;
  logic          s1_zero_s;
  logic [N-1:0]  s2_mant_s;

  logic          s1_valid_r;
  logic          s1_sign_r;
  logic [N-1:0]  s1_mag_r;
  logic          s2_valid_r;
  logic          s2_sign_r;
  logic          s2_zero_r;
  logic [N-1:0]  s2_mag_r;
  logic [SW-1:0] s2_clz_r;

  // Global stall: the whole pipeline moves only when S3 can be vacated.
  always_comb begin
    advance_s = !out_valid || out_ready;
  end

  assign in_ready = advance_s;

  // Sign and magnitude of the incoming operand. Negation wraps in N bits, so
  // the most negative value maps to 2^(N-1), which is still a valid magnitude.
  always_comb begin
    s1_sign_nxt_s = SIGNED && in_data[N-1];
    if (s1_sign_nxt_s) begin
      s1_mag_nxt_s = ~in_data + {{(N-1){1'b0}}, 1'b1};
    end else begin
      s1_mag_nxt_s = in_data;
    end
  end

  // Stage 1 register: sign, magnitude and slot valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_mag_r   <= {N{1'b0}};
    end else if (advance_s) begin
      s1_valid_r <= in_valid && advance_s;
      s1_sign_r  <= s1_sign_nxt_s;
      s1_mag_r   <= s1_mag_nxt_s;
    end
  end

  fixed_point_clz_tree #(
    .N (N)
  ) u_clz_tree (
    .data (s1_mag_r),
    .clz  (s1_clz_s)
  );

  // Zero detect on the stage 1 magnitude.
  always_comb begin
    s1_zero_s = (s1_mag_r == {N{1'b0}});
  end

  // Stage 2 register: magnitude, sign, zero flag and leading-zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_sign_r  <= 1'b0;
      s2_zero_r  <= 1'b0;
      s2_mag_r   <= {N{1'b0}};
      s2_clz_r   <= {SW{1'b0}};
    end else if (advance_s) begin
      s2_valid_r <= s1_valid_r;
      s2_sign_r  <= s1_sign_r;
      s2_zero_r  <= s1_zero_s;
      s2_mag_r   <= s1_mag_r;
      s2_clz_r   <= s1_clz_s;
    end
  end

  // Normalizing shift; a zero magnitude has count 0 and stays 0.
  always_comb begin
    s2_mant_s = s2_mag_r << s2_clz_r;
  end

  // Stage 3 register, which is also the output interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mant  <= {N{1'b0}};
      out_shift <= {SW{1'b0}};
      out_sign  <= 1'b0;
      out_zero  <= 1'b0;
    end else if (advance_s) begin
      out_valid <= s2_valid_r;
      out_mant  <= s2_mant_s;
      out_shift <= s2_clz_r;
      out_sign  <= s2_sign_r;
      out_zero  <= s2_zero_r;
    end
  end

endmodule
